// File: rtl/i2c_target_regs.sv
// I2C target that owns a 2**REG_AW x 8 register file: write = pointer byte then
// data bytes, read = bytes from the current pointer. Host port can preload registers.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h68,
    parameter int         REG_AW   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    input  logic              host_wr_en,
    input  logic [REG_AW-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              bus_wr_valid,
    output logic [REG_AW-1:0] bus_wr_addr,
    output logic [7:0]        bus_wr_data,
    output logic              busy,
    output logic [3:0]        dbg_state
);

    localparam int                NUM_REGS = 2 ** REG_AW;
    localparam logic [REG_AW-1:0] PTR_ONE  = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_IGNORE
    } state_t;

    logic              scl_meta_q, scl_sync_q, scl_prev_q;
    logic              sda_meta_q, sda_sync_q, sda_prev_q;
    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [7:0]        sh_q;
    logic              rw_q;
    logic [REG_AW-1:0] ptr_q;
    logic              sda_oe_q;
    logic              busy_q;
    logic              wr_valid_q;
    logic [REG_AW-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic [7:0]        regs_q [NUM_REGS];

    logic       scl_rise, scl_fall, sda_rise, sda_fall;
    logic       start_det, stop_det, last_bit;
    logic [7:0] byte_in, rd_byte;

    // Pads are idle-high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    assign scl_rise  = scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q & scl_prev_q;
    assign sda_rise  = sda_sync_q & ~sda_prev_q;
    assign sda_fall  = ~sda_sync_q & sda_prev_q;
    assign start_det = sda_fall & scl_sync_q;
    assign stop_det  = sda_rise & scl_sync_q;
    assign last_bit  = (cnt_q == 4'd7);
    assign byte_in   = {sh_q[6:0], sda_sync_q};
    assign rd_byte   = regs_q[ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            sh_q       <= 8'h00;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            wr_valid_q <= 1'b0;
            // Host write first so a bus write to the same register overrides it.
            if (host_wr_en) begin
                regs_q[host_addr] <= host_wdata;
            end
            if (start_det) begin
                state_q  <= S_ADDR;
                cnt_q    <= 4'd0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b1;
            end else if (stop_det) begin
                state_q  <= S_IDLE;
                cnt_q    <= 4'd0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR: begin
                        if (scl_rise) begin
                            sh_q  <= byte_in;
                            cnt_q <= cnt_q + 4'd1;
                            if (last_bit) begin
                                cnt_q   <= 4'd0;
                                rw_q    <= sda_sync_q;
                                state_q <= (byte_in[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
                            end
                        end
                    end
                    S_PTR: begin
                        if (scl_rise) begin
                            sh_q  <= byte_in;
                            cnt_q <= cnt_q + 4'd1;
                            if (last_bit) begin
                                cnt_q   <= 4'd0;
                                ptr_q   <= byte_in[REG_AW-1:0];
                                state_q <= S_PTR_ACK;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (scl_rise) begin
                            sh_q  <= byte_in;
                            cnt_q <= cnt_q + 4'd1;
                            if (last_bit) begin
                                cnt_q         <= 4'd0;
                                regs_q[ptr_q] <= byte_in;
                                wr_valid_q    <= 1'b1;
                                wr_addr_q     <= ptr_q;
                                wr_data_q     <= byte_in;
                                ptr_q         <= ptr_q + PTR_ONE;
                                state_q       <= S_WDATA_ACK;
                            end
                        end
                    end
                    // First SCL fall pulls SDA for the ACK slot, the second ends it.
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            cnt_q <= 4'd0;
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else if (rw_q) begin
                                sh_q     <= {rd_byte[6:0], 1'b0};
                                sda_oe_q <= ~rd_byte[7];
                                ptr_q    <= ptr_q + PTR_ONE;
                                state_q  <= S_RDATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= S_PTR;
                            end
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: begin
                        if (scl_fall) begin
                            cnt_q <= 4'd0;
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= S_WDATA;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise) begin
                            cnt_q <= cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (cnt_q == 4'd8) begin
                                cnt_q    <= 4'd0;
                                sda_oe_q <= 1'b0;
                                state_q  <= S_RDATA_ACK;
                            end else begin
                                sda_oe_q <= ~sh_q[7];
                                sh_q     <= {sh_q[6:0], 1'b0};
                            end
                        end
                    end
                    // A fall here can only follow an ACK rise; NACK leaves on the rise.
                    S_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_sync_q) begin
                                state_q <= S_IGNORE;
                            end
                        end else if (scl_fall) begin
                            sh_q     <= {rd_byte[6:0], 1'b0};
                            sda_oe_q <= ~rd_byte[7];
                            ptr_q    <= ptr_q + PTR_ONE;
                            cnt_q    <= 4'd0;
                            state_q  <= S_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe       = sda_oe_q;
    assign busy         = busy_q;
    assign bus_wr_valid = wr_valid_q;
    assign bus_wr_addr  = wr_addr_q;
    assign bus_wr_data  = wr_data_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, open-drain SDA model,
// register model and a queue of expected bus-side register writes.
module tb_i2c_target_regs;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic       host_wr_en = 1'b0;
    logic [3:0] host_addr = 4'h0;
    logic [7:0] host_wdata = 8'h00;
    logic       bus_wr_valid;
    logic [3:0] bus_wr_addr;
    logic [7:0] bus_wr_data;
    logic       busy;
    logic [3:0] dbg_state;

    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_pulses = 0;
    logic        oe_seen = 1'b0;
    logic [11:0] exp_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  model[16];
    logic [3:0]  coll_addr = 4'h0;
    logic [7:0]  coll_data = 8'h00;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regs #(.DEV_ADDR(7'h68), .REG_AW(4)) dut (
        .clk(clk), .reset(reset), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
        .host_wr_en(host_wr_en), .host_addr(host_addr), .host_wdata(host_wdata),
        .bus_wr_valid(bus_wr_valid), .bus_wr_addr(bus_wr_addr), .bus_wr_data(bus_wr_data),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && sda_oe) oe_seen = 1'b1;
        if (!reset && bus_wr_valid) begin
            wr_pulses++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL bus_wr unexpected: got addr=%0h data=%02h, none expected", bus_wr_addr, bus_wr_data);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({bus_wr_addr, bus_wr_data} !== e) begin
                    n_fail++;
                    $display("FAIL bus_wr: got addr=%0h data=%02h, expected addr=%0h data=%02h",
                             bus_wr_addr, bus_wr_data, e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_wr_en = 1'b1; host_addr = a; host_wdata = d;
        wait_clk(1);
        host_wr_en = 1'b0;
        model[a] = d;
    endtask

    // One SCL period of 16 clk; optional host write lands on the clk the target samples this bit.
    task automatic clock_bit(input logic b, input bit collide, output logic s);
        scl = 1'b0; wait_clk(4);
        sda_m = b;  wait_clk(4);
        scl = 1'b1; wait_clk(2);
        if (collide) begin
            host_wr_en = 1'b1; host_addr = coll_addr; host_wdata = coll_data;
        end
        wait_clk(1);
        host_wr_en = 1'b0;
        wait_clk(1);
        s = sda_line;
        wait_clk(4);
    endtask

    task automatic i2c_start();
        scl = 1'b0;   wait_clk(4);
        sda_m = 1'b1; wait_clk(4);
        scl = 1'b1;   wait_clk(4);
        sda_m = 1'b0; wait_clk(8);
    endtask

    task automatic i2c_stop();
        scl = 1'b0;   wait_clk(4);
        sda_m = 1'b0; wait_clk(4);
        scl = 1'b1;   wait_clk(4);
        sda_m = 1'b1; wait_clk(8);
    endtask

    task automatic write_byte(input logic [7:0] b, input bit collide_last, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], collide_last && (i == 0), s);
        clock_bit(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        clock_bit(nack, 1'b0, s);
    endtask

    task automatic test_reset();
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b, expected 0", sda_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_checks++; if (bus_wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b, expected 0", bus_wr_valid); end
        n_checks++; if (bus_wr_addr !== 4'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %0h, expected 0", bus_wr_addr); end
        n_checks++; if (bus_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %02h, expected 00", bus_wr_data); end
        n_checks++; if (dbg_state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", dbg_state); end
    endtask

    task automatic test_write();
        logic       ack;
        logic [7:0] d, e;
        logic [7:0] bytes[4];
        bytes = '{8'hD0, 8'h02, 8'h12, 8'h34};
        host_write(4'h4, 8'h5A);
        i2c_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b, expected 1", busy); end
        for (int i = 0; i < 4; i++) begin
            if (i >= 2) begin
                exp_q.push_back({4'(i), bytes[i]});
                model[i] = bytes[i];
            end
            write_byte(bytes[i], 1'b0, ack);
            n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL write_ack byte%0d: got %b, expected 0", i, ack); end
        end
        i2c_stop();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_stop: got %b, expected 0", busy); end
        n_checks++; if (wr_pulses !== 2) begin n_fail++; $display("FAIL write_pulses: got %0d, expected 2", wr_pulses); end
        // A read with no pointer byte continues at ptr=4.
        i2c_start();
        write_byte(8'hD1, 1'b0, ack);
        rd_q.push_back(model[4]);
        read_byte(1'b1, d);
        e = rd_q.pop_front();
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL write_ptr_persist: got %02h, expected %02h", d, e); end
        i2c_stop();
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] d, e;
        i2c_start();
        write_byte(8'hD0, 1'b0, ack);
        write_byte(8'h02, 1'b0, ack);
        i2c_start();
        write_byte(8'hD1, 1'b0, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL read_addr_ack: got %b, expected 0", ack); end
        rd_q.push_back(model[2]);
        rd_q.push_back(model[3]);
        for (int i = 0; i < 2; i++) begin
            read_byte(i == 1, d);
            e = rd_q.pop_front();
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL read_byte%0d: got %02h, expected %02h", i, d, e); end
        end
        wait_clk(2);
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL read_nack_release: got %b, expected 0", sda_oe); end
        i2c_stop();
    endtask

    task automatic test_wrong_addr();
        logic ack;
        int   pulses0;
        pulses0 = wr_pulses;
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'hA0, 1'b0, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wrong_addr_ack: got %b, expected 1", ack); end
        write_byte(8'h55, 1'b0, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wrong_data_ack: got %b, expected 1", ack); end
        i2c_stop();
        n_checks++; if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_oe: got %b, expected 0", oe_seen); end
        n_checks++; if (wr_pulses !== pulses0) begin n_fail++; $display("FAIL wrong_addr_pulses: got %0d, expected %0d", wr_pulses, pulses0); end
    endtask

    task automatic test_readback_all();
        logic       ack;
        logic [7:0] d, e;
        i2c_start();
        write_byte(8'hD0, 1'b0, ack);
        write_byte(8'h00, 1'b0, ack);
        i2c_start();
        write_byte(8'hD1, 1'b0, ack);
        for (int i = 0; i < 16; i++) rd_q.push_back(model[i]);
        for (int i = 0; i < 16; i++) begin
            read_byte(i == 15, d);
            e = rd_q.pop_front();
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL readback reg%0d: got %02h, expected %02h", i, d, e); end
        end
        i2c_stop();
    endtask

    task automatic test_wrap();
        logic       ack;
        logic [7:0] d, e;
        i2c_start();
        write_byte(8'hD0, 1'b0, ack);
        write_byte(8'h0F, 1'b0, ack);
        exp_q.push_back({4'hF, 8'hAA}); model[15] = 8'hAA;
        write_byte(8'hAA, 1'b0, ack);
        exp_q.push_back({4'h0, 8'hBB}); model[0] = 8'hBB;
        write_byte(8'hBB, 1'b0, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wrap_ack: got %b, expected 0", ack); end
        i2c_stop();
        i2c_start();
        write_byte(8'hD0, 1'b0, ack);
        write_byte(8'h0F, 1'b0, ack);
        i2c_start();
        write_byte(8'hD1, 1'b0, ack);
        rd_q.push_back(model[15]);
        rd_q.push_back(model[0]);
        for (int i = 0; i < 2; i++) begin
            read_byte(i == 1, d);
            e = rd_q.pop_front();
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL wrap_read%0d: got %02h, expected %02h", i, d, e); end
        end
        i2c_stop();
    endtask

    task automatic test_collision();
        logic       ack;
        logic [7:0] d, e;
        logic [3:0] caddr[2];
        logic [7:0] cdata[2];
        logic [7:0] bdata[2];
        caddr = '{4'h5, 4'h6};
        cdata = '{8'h77, 8'h66};
        bdata = '{8'h99, 8'h9A};
        for (int t = 0; t < 2; t++) begin
            coll_addr = caddr[t];
            coll_data = cdata[t];
            i2c_start();
            write_byte(8'hD0, 1'b0, ack);
            write_byte(8'h05, 1'b0, ack);
            model[caddr[t]] = cdata[t];
            model[5] = bdata[t];
            exp_q.push_back({4'h5, bdata[t]});
            write_byte(bdata[t], 1'b1, ack);
            i2c_stop();
            i2c_start();
            write_byte(8'hD0, 1'b0, ack);
            write_byte(8'h05, 1'b0, ack);
            i2c_start();
            write_byte(8'hD1, 1'b0, ack);
            rd_q.push_back(model[5]);
            rd_q.push_back(model[6]);
            for (int i = 0; i < 2; i++) begin
                read_byte(i == 1, d);
                e = rd_q.pop_front();
                n_checks++; if (d !== e) begin n_fail++; $display("FAIL collision%0d reg%0d: got %02h, expected %02h", t, 5 + i, d, e); end
            end
            i2c_stop();
        end
    endtask

    task automatic test_abort();
        logic       ack, s;
        logic [7:0] d, e;
        int         pulses0;
        host_write(4'h0, 8'h00);
        pulses0 = wr_pulses;
        i2c_start();
        write_byte(8'hD0, 1'b0, ack);
        write_byte(8'h00, 1'b0, ack);
        i2c_start();
        write_byte(8'hD1, 1'b0, ack);
        for (int i = 0; i < 7; i++) clock_bit(1'b1, 1'b0, s);
        scl = 1'b0; wait_clk(4);
        n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL abort_drive_bit0: got %b, expected 1", sda_oe); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL abort_reset_release: got %b, expected 0", sda_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_reset_busy: got %b, expected 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        scl = 1'b1; sda_m = 1'b1; wait_clk(8);
        // STOP four bits into a data byte: no write, ptr stays at 7.
        host_write(4'h7, 8'h3C);
        i2c_start();
        write_byte(8'hD0, 1'b0, ack);
        write_byte(8'h07, 1'b0, ack);
        clock_bit(1'b1, 1'b0, s);
        clock_bit(1'b0, 1'b0, s);
        clock_bit(1'b1, 1'b0, s);
        clock_bit(1'b0, 1'b0, s);
        i2c_stop();
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL abort_stop_release: got %b, expected 0", sda_oe); end
        n_checks++; if (wr_pulses !== pulses0) begin n_fail++; $display("FAIL abort_pulses: got %0d, expected %0d", wr_pulses, pulses0); end
        i2c_start();
        write_byte(8'hD1, 1'b0, ack);
        rd_q.push_back(model[7]);
        read_byte(1'b1, d);
        e = rd_q.pop_front();
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL abort_ptr: got %02h, expected %02h", d, e); end
        i2c_stop();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(2);
        test_reset();
        test_write();
        test_read();
        test_wrong_addr();
        test_readback_all();
        test_wrap();
        test_collision();
        test_abort();
        test_readback_all();
        wait_clk(4);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wr_queue_drained: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
